// File: rtl/serial_tx_scheduler.sv
// Round-robin arbiter that shares one serial line between NREQ requesters.
// Frames go out as start, port (MSB first), length (MSB first), payload (LSB first), stop.
module serial_tx_scheduler #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned PORT_W = 2,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            bit_en,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*PORT_W-1:0]          port_in,
  input  logic [NREQ*LEN_W-1:0]           len_in,
  input  logic [NREQ*(2**LEN_W-1)-1:0]    data_in,
  output logic [NREQ-1:0]                 grant,
  output logic                            ser_out,
  output logic                            busy,
  output logic [$clog2(NREQ)-1:0]         cur_id,
  output logic                            done
);

  localparam int unsigned DATA_W = 2**LEN_W - 1;
  localparam int unsigned ID_W   = $clog2(NREQ);
  localparam int unsigned CNT_W  = (LEN_W > PORT_W) ? LEN_W : PORT_W;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StPort,
    StLen,
    StData,
    StStop
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     cur_id_q;
  logic                ser_out_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PORT_W-1:0]   port_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    len_sh_q;
  logic [DATA_W-1:0]   data_q;

  logic                found;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     ptr_nxt;
  logic                take;

  // Scan from the pointer upward, wrapping, and keep the first request seen.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req[(int'(ptr_q) + i) % int'(NREQ)]) begin
        found = 1'b1;
        sel   = ID_W'((int'(ptr_q) + i) % int'(NREQ));
      end
    end
  end

  assign ptr_nxt = (sel == ID_W'(NREQ - 1)) ? '0 : sel + ID_W'(1);
  assign take    = (state_q == StIdle) && bit_en && found && !reset;

  always_comb begin
    grant = '0;
    if (take) begin
      grant[sel] = 1'b1;
    end
  end

  assign done    = (state_q == StStop) && bit_en && !reset;
  assign busy    = (state_q != StIdle);
  assign ser_out = ser_out_q;
  assign cur_id  = cur_id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cur_id_q  <= '0;
      ser_out_q <= 1'b1;
      cnt_q     <= '0;
      port_q    <= '0;
      len_q     <= '0;
      len_sh_q  <= '0;
      data_q    <= '0;
    end else if (bit_en) begin
      case (state_q)
        StIdle: begin
          ser_out_q <= 1'b1;
          if (found) begin
            port_q    <= port_in[int'(sel)*int'(PORT_W) +: PORT_W];
            len_q     <= len_in[int'(sel)*int'(LEN_W) +: LEN_W];
            len_sh_q  <= len_in[int'(sel)*int'(LEN_W) +: LEN_W];
            data_q    <= data_in[int'(sel)*int'(DATA_W) +: DATA_W];
            cur_id_q  <= sel;
            ptr_q     <= ptr_nxt;
            ser_out_q <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          ser_out_q <= port_q[PORT_W-1];
          port_q    <= port_q << 1;
          cnt_q     <= '0;
          state_q   <= StPort;
        end
        StPort: begin
          if (cnt_q == CNT_W'(PORT_W - 1)) begin
            ser_out_q <= len_sh_q[LEN_W-1];
            len_sh_q  <= len_sh_q << 1;
            cnt_q     <= '0;
            state_q   <= StLen;
          end else begin
            ser_out_q <= port_q[PORT_W-1];
            port_q    <= port_q << 1;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        StLen: begin
          if (cnt_q == CNT_W'(LEN_W - 1)) begin
            cnt_q <= '0;
            if (len_q != '0) begin
              ser_out_q <= data_q[0];
              data_q    <= data_q >> 1;
              state_q   <= StData;
            end else begin
              ser_out_q <= 1'b1;
              state_q   <= StStop;
            end
          end else begin
            ser_out_q <= len_sh_q[LEN_W-1];
            len_sh_q  <= len_sh_q << 1;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        StData: begin
          // cnt_q is the index of the payload bit currently on the line.
          if (cnt_q + CNT_W'(1) == CNT_W'(len_q)) begin
            ser_out_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StStop;
          end else begin
            ser_out_q <= data_q[0];
            data_q    <= data_q >> 1;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        StStop: begin
          ser_out_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          ser_out_q <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule
